main_sa_cache: RTL and testbench



---
 rtl/main_sa_cache_if.sv | 20 ++
 rtl/main_sa_cache.sv | 183 ++++++++++++++++++
 tb/tb_main_sa_cache.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/main_sa_cache_if.sv
// Trace-source <-> cache bundle: address handshake in, completion pulse and hit/miss counters out.
interface main_sa_cache_if #(
    parameter int ADDR_W = 32
);
    logic              trace_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              update_lru;
    logic [31:0]       cache_hit_count;
    logic [31:0]       cache_miss_count;

    modport master (
        output trace_ready, mem_addr,
        input  update_lru, cache_hit_count, cache_miss_count
    );

    modport slave (
        input  trace_ready, mem_addr,
        output update_lru, cache_hit_count, cache_miss_count
    );
endinterface

// File: rtl/main_sa_cache.sv
// Tag-only set-associative cache model with true-LRU ages; classifies one trace address per
// rising-edge handshake and keeps running hit/miss counters.
module main_sa_cache #(
    parameter int ADDR_W      = 32,
    parameter int OFFSET_BITS = 6,
    parameter int INDEX_BITS  = 6,
    parameter int WAYS        = 4,
    parameter int LRU_W       = 2
) (
    input logic           clk,
    input logic           rst_n,
    main_sa_cache_if.slave bus
);

    localparam int TAG_W = ADDR_W - INDEX_BITS - OFFSET_BITS;
    localparam int SETS  = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        UPDATE
    } state_t;

    typedef logic [WAYS-1:0][TAG_W-1:0] tag_row_t;
    typedef logic [WAYS-1:0][LRU_W-1:0] age_row_t;

    function automatic age_row_t age_init();
        age_row_t r;
        for (int w = 0; w < WAYS; w++) begin
            r[w] = LRU_W'(w);
        end
        return r;
    endfunction

    localparam age_row_t AGE_INIT = age_init();

    state_t                 state_q, state_d;
    logic                   trace_ready_q;
    logic [TAG_W-1:0]       req_tag_q, req_tag_d;
    logic [INDEX_BITS-1:0]  req_index_q, req_index_d;
    logic                   hit_q, hit_d;
    logic [LRU_W-1:0]       way_q, way_d;
    logic                   update_lru_q, update_lru_d;
    logic [31:0]            hit_count_q, hit_count_d;
    logic [31:0]            miss_count_q, miss_count_d;

    tag_row_t               tag_mem_q   [SETS];
    tag_row_t               tag_mem_d   [SETS];
    logic [WAYS-1:0]        valid_mem_q [SETS];
    logic [WAYS-1:0]        valid_mem_d [SETS];
    age_row_t               age_mem_q   [SETS];
    age_row_t               age_mem_d   [SETS];

    logic                   look_hit;
    logic [LRU_W-1:0]       look_hit_way;
    logic                   inv_found;
    logic [LRU_W-1:0]       inv_way;
    logic [LRU_W-1:0]       lru_way;
    logic [LRU_W-1:0]       old_age;
    age_row_t               new_age_row;
    logic                   accept;

    // Byte offset never affects classification.
    logic unused_offset;
    assign unused_offset = ^bus.mem_addr[OFFSET_BITS-1:0];

    // Set lookup: matching way, lowest invalid way and the oldest way of the latched set.
    always_comb begin
        look_hit     = 1'b0;
        look_hit_way = '0;
        inv_found    = 1'b0;
        inv_way      = '0;
        lru_way      = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_mem_q[req_index_q][w] && (tag_mem_q[req_index_q][w] == req_tag_q)) begin
                look_hit     = 1'b1;
                look_hit_way = LRU_W'(w);
            end
            if (age_mem_q[req_index_q][w] == LRU_W'(WAYS - 1)) begin
                lru_way = LRU_W'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_mem_q[req_index_q][w]) begin
                inv_found = 1'b1;
                inv_way   = LRU_W'(w);
            end
        end
    end

    // Ages younger than the accessed way shift up by one; the accessed way becomes youngest.
    always_comb begin
        old_age     = age_mem_q[req_index_q][way_q];
        new_age_row = age_mem_q[req_index_q];
        for (int w = 0; w < WAYS; w++) begin
            if (LRU_W'(w) == way_q) begin
                new_age_row[w] = '0;
            end else if (age_mem_q[req_index_q][w] < old_age) begin
                new_age_row[w] = age_mem_q[req_index_q][w] + LRU_W'(1);
            end
        end
    end

    assign accept = (state_q == IDLE) && bus.trace_ready && !trace_ready_q;

    always_comb begin
        state_d      = state_q;
        req_tag_d    = req_tag_q;
        req_index_d  = req_index_q;
        hit_d        = hit_q;
        way_d        = way_q;
        update_lru_d = 1'b0;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        tag_mem_d    = tag_mem_q;
        valid_mem_d  = valid_mem_q;
        age_mem_d    = age_mem_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    req_tag_d   = bus.mem_addr[ADDR_W-1 -: TAG_W];
                    req_index_d = bus.mem_addr[OFFSET_BITS +: INDEX_BITS];
                    state_d     = LOOKUP;
                end
            end
            LOOKUP: begin
                hit_d        = look_hit;
                way_d        = look_hit ? look_hit_way : (inv_found ? inv_way : lru_way);
                update_lru_d = 1'b1;
                state_d      = UPDATE;
            end
            UPDATE: begin
                if (hit_q) begin
                    hit_count_d = hit_count_q + 32'd1;
                end else begin
                    miss_count_d                   = miss_count_q + 32'd1;
                    tag_mem_d[req_index_q][way_q]  = req_tag_q;
                    valid_mem_d[req_index_q][way_q] = 1'b1;
                end
                age_mem_d[req_index_q] = new_age_row;
                state_d                = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset has priority, so an access in flight is dropped without touching arrays or counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            trace_ready_q <= 1'b0;
            req_tag_q     <= '0;
            req_index_q   <= '0;
            hit_q         <= 1'b0;
            way_q         <= '0;
            update_lru_q  <= 1'b0;
            hit_count_q   <= '0;
            miss_count_q  <= '0;
            tag_mem_q     <= '{default: '0};
            valid_mem_q   <= '{default: '0};
            age_mem_q     <= '{default: AGE_INIT};
        end else begin
            state_q       <= state_d;
            trace_ready_q <= bus.trace_ready;
            req_tag_q     <= req_tag_d;
            req_index_q   <= req_index_d;
            hit_q         <= hit_d;
            way_q         <= way_d;
            update_lru_q  <= update_lru_d;
            hit_count_q   <= hit_count_d;
            miss_count_q  <= miss_count_d;
            tag_mem_q     <= tag_mem_d;
            valid_mem_q   <= valid_mem_d;
            age_mem_q     <= age_mem_d;
        end
    end

    assign bus.update_lru       = update_lru_q;
    assign bus.cache_hit_count  = hit_count_q;
    assign bus.cache_miss_count = miss_count_q;

endmodule

// File: tb/tb_main_sa_cache.sv
// Self-checking bench for main_sa_cache: directed trace scenarios plus random traffic checked
// against a recency-list model of a 64-set, 4-way LRU cache.
module tb_main_sa_cache;

    logic clk;
    logic rst_n;

    main_sa_cache_if bus ();

    main_sa_cache dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int num_checks;
    int num_errors;

    logic [19:0] m_tag   [64][4];
    bit          m_valid [64][4];
    int          m_order [64][$];
    logic [31:0] exp_hits;
    logic [31:0] exp_misses;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 64; s++) begin
            m_order[s].delete();
            for (int w = 0; w < 4; w++) begin
                m_valid[s][w] = 1'b0;
                m_tag[s][w]   = '0;
                m_order[s].push_back(w);
            end
        end
        exp_hits   = '0;
        exp_misses = '0;
    endtask

    // Recency list per set: front is most recent, back is the LRU victim.
    task automatic model_access(input logic [31:0] addr, output bit hit);
        int          idx;
        logic [19:0] tag;
        int          way;
        idx = int'(addr[11:6]);
        tag = addr[31:12];
        way = -1;
        hit = 1'b0;
        for (int w = 0; w < 4; w++) begin
            if (m_valid[idx][w] && m_tag[idx][w] == tag) begin
                hit = 1'b1;
                way = w;
            end
        end
        if (!hit) begin
            for (int w = 3; w >= 0; w--) begin
                if (!m_valid[idx][w]) way = w;
            end
            if (way < 0) way = m_order[idx][$];
        end
        for (int p = 0; p < m_order[idx].size(); p++) begin
            if (m_order[idx][p] == way) begin
                m_order[idx].delete(p);
                break;
            end
        end
        m_order[idx].push_front(way);
        m_valid[idx][way] = 1'b1;
        m_tag[idx][way]   = tag;
        if (hit) exp_hits = exp_hits + 32'd1;
        else     exp_misses = exp_misses + 32'd1;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n            = 1'b0;
        bus.trace_ready  = 1'b0;
        bus.mem_addr     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        checkOutput("rst_lru", {31'd0, bus.update_lru}, 32'd0);
        checkOutput("rst_hits", bus.cache_hit_count, 32'd0);
        checkOutput("rst_misses", bus.cache_miss_count, 32'd0);
    endtask

    // One-cycle trace_ready pulse; checks pulse timing and counters around the access.
    task automatic applyStimulus(input logic [31:0] addr);
        bit          hit;
        logic [31:0] old_hits;
        logic [31:0] old_misses;
        old_hits   = exp_hits;
        old_misses = exp_misses;
        @(negedge clk);
        bus.mem_addr    = addr;
        bus.trace_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("lru_at_accept", {31'd0, bus.update_lru}, 32'd0);
        model_access(addr, hit);
        @(negedge clk);
        bus.trace_ready = 1'b0;
        bus.mem_addr    = $urandom;
        @(posedge clk);
        #1;
        checkOutput("lru_pulse", {31'd0, bus.update_lru}, 32'd1);
        checkOutput("hits_before", bus.cache_hit_count, old_hits);
        checkOutput("misses_before", bus.cache_miss_count, old_misses);
        @(posedge clk);
        #1;
        checkOutput("lru_after", {31'd0, bus.update_lru}, 32'd0);
        checkOutput("hits", bus.cache_hit_count, exp_hits);
        checkOutput("misses", bus.cache_miss_count, exp_misses);
    endtask

    // Drives trace_ready per edge from pat (bit i = level at edge i); exactly one access expected.
    task automatic runPattern(input logic [31:0] addr, input logic [11:0] pat, input string tag);
        bit hit;
        int pulses;
        pulses = 0;
        bus.mem_addr = addr;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bus.trace_ready = pat[i];
            @(posedge clk);
            #1;
            if (bus.update_lru) pulses++;
        end
        model_access(addr, hit);
        checkOutput({tag, "_pulses"}, pulses, 32'd1);
        checkOutput({tag, "_hits"}, bus.cache_hit_count, exp_hits);
        checkOutput({tag, "_misses"}, bus.cache_miss_count, exp_misses);
    endtask

    initial begin
        num_checks      = 0;
        num_errors      = 0;
        rst_n           = 1'b0;
        bus.trace_ready = 1'b0;
        bus.mem_addr    = '0;
        model_reset();

        doReset();
        applyStimulus(32'h0000_0000);
        checkOutput("plan1_miss", bus.cache_miss_count, 32'd1);
        applyStimulus(32'h0000_0000);
        applyStimulus(32'h0000_003F);
        checkOutput("plan2_hits", bus.cache_hit_count, 32'd2);
        checkOutput("plan2_misses", bus.cache_miss_count, 32'd1);

        doReset();
        applyStimulus(32'h0000_0000);
        applyStimulus(32'h0000_1000);
        applyStimulus(32'h0000_2000);
        applyStimulus(32'h0000_3000);
        checkOutput("fill_misses", bus.cache_miss_count, 32'd4);
        applyStimulus(32'h0000_4000);
        applyStimulus(32'h0000_0000);
        applyStimulus(32'h0000_2000);
        checkOutput("evict_hits", bus.cache_hit_count, 32'd1);
        checkOutput("evict_misses", bus.cache_miss_count, 32'd6);

        doReset();
        applyStimulus(32'h0000_0000);
        applyStimulus(32'h0000_1000);
        applyStimulus(32'h0000_2000);
        applyStimulus(32'h0000_3000);
        applyStimulus(32'h0000_0000);
        applyStimulus(32'h0000_4000);
        applyStimulus(32'h0000_0000);
        checkOutput("refresh_hits", bus.cache_hit_count, 32'd2);
        applyStimulus(32'h0000_1000);
        checkOutput("refresh_misses", bus.cache_miss_count, 32'd6);

        runPattern(32'h0000_5040, 12'b0000_0001_1111, "hold");
        runPattern(32'h0000_5040, 12'b0000_0111_1101, "rise_busy");
        checkOutput("hold_final_hits", bus.cache_hit_count, 32'd3);

        // Reset lands on the LOOKUP edge of an access to a line that is already cached.
        doReset();
        applyStimulus(32'h0000_0000);
        @(negedge clk);
        bus.mem_addr    = 32'h0000_0000;
        bus.trace_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.trace_ready = 1'b0;
        rst_n           = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort_lru", {31'd0, bus.update_lru}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("abort_no_pulse", {31'd0, bus.update_lru}, 32'd0);
        end
        checkOutput("abort_hits", bus.cache_hit_count, 32'd0);
        checkOutput("abort_misses", bus.cache_miss_count, 32'd0);
        applyStimulus(32'h0000_0000);
        checkOutput("abort_remiss", bus.cache_miss_count, 32'd1);

        // Few tags over few sets so hits, fills and evictions all occur.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] addr;
            addr = ({12'd0, 20'($urandom_range(0, 6))} << 12)
                 | ({26'd0, 6'($urandom_range(0, 2))} << 6)
                 | {26'd0, 6'($urandom)};
            applyStimulus(addr);
        end

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
